// File: rtl/controlador_memoria_dados_pkg.sv
// Shared processor definitions: memory-access FSM states and writeback mux selects.
// Latency: none, constants and a pure helper only.
// Backpressure: not applicable.
package pacote_processador;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        ACESSO    = 2'd1,
        ESPERA    = 2'd2,
        CONCLUIDO = 2'd3
    } estado_t;

    localparam logic SEL_ULA = 1'b0;
    localparam logic SEL_MEM = 1'b1;

    // Word accesses only: the two low byte-address bits must be zero.
    function automatic logic alinhado(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/controlador_memoria_dados_contador_timeout.sv
// Saturating wait counter for the ESPERA state; flags the last permitted wait cycle.
// Latency: expirou is combinational from the registered count.
// Backpressure: none, habilita simply stalls the count.
module contador_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    input  logic habilita,
    output logic expirou
);

    localparam int LARG = $clog2(TIMEOUT + 1);
    localparam logic [LARG-1:0] ULTIMO = LARG'(TIMEOUT - 1);
    localparam logic [LARG-1:0] SATURA = LARG'(TIMEOUT);

    logic [LARG-1:0] contagem;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem <= '0;
        end else if (limpa) begin
            contagem <= '0;
        end else if (habilita && (contagem != SATURA)) begin
            contagem <= contagem + 1'b1;
        end
    end

    assign expirou = (contagem >= ULTIMO);

endmodule

// File: rtl/controlador_memoria_dados.sv
// Data-memory access sequencer: one load/store/no-op per inicio, drives memory handshake and writeback select.
// Latency: memory op 3 + N cycles (N = wait for mem_pronta), rejected or no-op request 1 cycle.
// Backpressure: inicio ignored while ocupado; a silent memory is aborted after TIMEOUT wait cycles.
module controlador_memoria_dados
    import pacote_processador::*;
#(
    parameter int LARG_DADOS = 32,
    parameter int LARG_END   = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inicio,
    input  logic                  op_load,
    input  logic                  op_store,
    input  logic [LARG_END-1:0]   endereco,
    input  logic [LARG_DADOS-1:0] dado_escrita,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [LARG_END-1:0]   mem_end,
    output logic [LARG_DADOS-1:0] mem_dado_esc,
    input  logic                  mem_pronta,
    input  logic [LARG_DADOS-1:0] mem_dado_lido,
    output logic [LARG_DADOS-1:0] dado_lido,
    output logic                  flag,
    output logic                  ocupado,
    output logic                  concluido,
    output logic                  erro
);

    estado_t estado;
    estado_t prox_estado;

    logic pedido_load;
    logic pedido_store;
    logic aceita;
    logic sem_op;
    logic rejeitado;
    logic expirou;
    logic limpa_cont;
    logic conta;

    assign aceita    = (estado == OCIOSO) && inicio;
    assign sem_op    = !op_load && !op_store;
    assign rejeitado = (op_load && op_store) || !alinhado(endereco[1:0]);

    // Counter sits at zero outside ESPERA, so every wait starts from a clean count.
    assign limpa_cont = (estado != ESPERA);
    assign conta      = (estado == ESPERA) && !mem_pronta;

    contador_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_contador (
        .clock    (clock),
        .reset    (reset),
        .limpa    (limpa_cont),
        .habilita (conta),
        .expirou  (expirou)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO: begin
                if (inicio) begin
                    if (sem_op || rejeitado) begin
                        prox_estado = CONCLUIDO;
                    end else begin
                        prox_estado = ACESSO;
                    end
                end
            end
            ACESSO: begin
                prox_estado = ESPERA;
            end
            ESPERA: begin
                // A completion arriving on the last allowed cycle still wins over the abort.
                if (mem_pronta || expirou) begin
                    prox_estado = CONCLUIDO;
                end
            end
            CONCLUIDO: begin
                prox_estado = OCIOSO;
            end
            default: begin
                prox_estado = OCIOSO;
            end
        endcase
    end

    // Memory strobes decode straight from state so an async reset drops them at once.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        ocupado   = (estado != OCIOSO);
        concluido = 1'b0;
        case (estado)
            ACESSO, ESPERA: begin
                mem_en = 1'b1;
                mem_we = pedido_store;
            end
            CONCLUIDO: begin
                concluido = 1'b1;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pedido_load  <= 1'b0;
            pedido_store <= 1'b0;
            mem_end      <= '0;
            mem_dado_esc <= '0;
            dado_lido    <= '0;
            flag         <= SEL_ULA;
            erro         <= 1'b0;
        end else if (aceita) begin
            pedido_load  <= op_load;
            pedido_store <= op_store;
            mem_end      <= endereco;
            mem_dado_esc <= dado_escrita;
            flag         <= SEL_ULA;
            erro         <= !sem_op && rejeitado;
        end else if (estado == ESPERA) begin
            if (mem_pronta) begin
                erro <= 1'b0;
                if (pedido_load) begin
                    dado_lido <= mem_dado_lido;
                    flag      <= SEL_MEM;
                end
            end else if (expirou) begin
                erro <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_controlador_memoria_dados.sv
// Scoreboard bench: a transaction-level model queues the expected completion and memory access per request,
// and an independent monitor pops and compares whenever concluido or mem_en is seen.
module tb_controlador_memoria_dados;

    localparam int LD = 32;
    localparam int LE = 32;
    localparam int TO = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          inicio = 1'b0;
    logic          op_load = 1'b0;
    logic          op_store = 1'b0;
    logic [LE-1:0] endereco = '0;
    logic [LD-1:0] dado_escrita = '0;
    logic          mem_en;
    logic          mem_we;
    logic [LE-1:0] mem_end;
    logic [LD-1:0] mem_dado_esc;
    logic          mem_pronta = 1'b0;
    logic [LD-1:0] mem_dado_lido = '0;
    logic [LD-1:0] dado_lido;
    logic          flag;
    logic          ocupado;
    logic          concluido;
    logic          erro;

    int testes = 0;
    int falhas = 0;
    int ciclo  = 0;

    typedef struct {
        int            ciclo;
        logic          erro;
        logic          flag;
        logic [LD-1:0] dado;
    } resp_t;

    typedef struct {
        logic          we;
        logic [LE-1:0] ende;
        logic [LD-1:0] dado;
        int            ciclos;
    } acesso_t;

    resp_t   fila_resp[$];
    acesso_t fila_mem[$];

    logic [LD-1:0] m_dado = '0;
    logic          m_flag = 1'b0;

    controlador_memoria_dados #(
        .LARG_DADOS (LD),
        .LARG_END   (LE),
        .TIMEOUT    (TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .inicio        (inicio),
        .op_load       (op_load),
        .op_store      (op_store),
        .endereco      (endereco),
        .dado_escrita  (dado_escrita),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_end       (mem_end),
        .mem_dado_esc  (mem_dado_esc),
        .mem_pronta    (mem_pronta),
        .mem_dado_lido (mem_dado_lido),
        .dado_lido     (dado_lido),
        .flag          (flag),
        .ocupado       (ocupado),
        .concluido     (concluido),
        .erro          (erro)
    );

    always #5 clock = ~clock;

    always @(posedge clock) ciclo <= ciclo + 1;

    task automatic checa(input string nome, input logic [63:0] obtido, input logic [63:0] esperado);
        testes++;
        if (obtido !== esperado) begin
            falhas++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nome, obtido, esperado, ciclo);
        end
    endtask

    // Monitor: independent of the driver, reacts only to what the DUT presents.
    resp_t   r_mon;
    acesso_t acc_atual;
    logic    acc_ativo = 1'b0;
    int      acc_cont  = 0;

    always @(negedge clock) begin
        if (reset) begin
            acc_ativo = 1'b0;
            acc_cont  = 0;
        end else begin
            if (concluido) begin
                if (fila_resp.size() == 0) begin
                    testes++;
                    falhas++;
                    $display("FAIL concluido_inesperado: got concluido=1 expected no completion (cycle %0d)", ciclo);
                end else begin
                    r_mon = fila_resp.pop_front();
                    checa("latencia", 64'(ciclo), 64'(r_mon.ciclo));
                    checa("erro", 64'(erro), 64'(r_mon.erro));
                    checa("flag", 64'(flag), 64'(r_mon.flag));
                    checa("dado_lido", 64'(dado_lido), 64'(r_mon.dado));
                    checa("ocupado_concluido", 64'(ocupado), 64'(1));
                end
            end else if (fila_resp.size() != 0 && fila_resp[0].ciclo < ciclo) begin
                r_mon = fila_resp.pop_front();
                testes++;
                falhas++;
                $display("FAIL concluido_ausente: got no completion expected one at cycle %0d", r_mon.ciclo);
            end

            if (mem_en) begin
                if (!acc_ativo) begin
                    if (fila_mem.size() == 0) begin
                        testes++;
                        falhas++;
                        $display("FAIL mem_en_inesperado: got mem_en=1 expected 0 (cycle %0d)", ciclo);
                    end else begin
                        acc_atual = fila_mem.pop_front();
                        acc_ativo = 1'b1;
                        acc_cont  = 0;
                    end
                end
                if (acc_ativo) begin
                    checa("mem_we", 64'(mem_we), 64'(acc_atual.we));
                    checa("mem_end", 64'(mem_end), 64'(acc_atual.ende));
                    checa("mem_dado_esc", 64'(mem_dado_esc), 64'(acc_atual.dado));
                    acc_cont++;
                end
            end else if (acc_ativo) begin
                checa("ciclos_mem_en", 64'(acc_cont), 64'(acc_atual.ciclos));
                acc_ativo = 1'b0;
            end
        end
    end

    // One request, issued at a negedge with the DUT idle; atraso = ESPERA cycles before mem_pronta (<0: never).
    task automatic pedido(input logic ld, input logic st, input logic [LE-1:0] ad,
                          input logic [LD-1:0] wd, input int atraso, input logic [LD-1:0] rd);
        int      k;
        int      lat;
        logic    acessa;
        resp_t   r;
        acesso_t a;
        k      = ciclo;
        acessa = 1'b0;
        if (!ld && !st) begin
            lat = 1;  r.erro = 1'b0;  m_flag = 1'b0;
        end else if ((ld && st) || (ad[1:0] != 2'b00)) begin
            lat = 1;  r.erro = 1'b1;  m_flag = 1'b0;
        end else begin
            acessa = 1'b1;
            if (atraso >= 0 && atraso < TO) begin
                lat = 3 + atraso;  r.erro = 1'b0;  m_flag = ld;
                if (ld) m_dado = rd;
                a.ciclos = 2 + atraso;
            end else begin
                lat = 2 + TO;  r.erro = 1'b1;  m_flag = 1'b0;
                a.ciclos = 1 + TO;
            end
            a.we = st;  a.ende = ad;  a.dado = wd;
            fila_mem.push_back(a);
        end
        r.ciclo = k + lat;
        r.flag  = m_flag;
        r.dado  = m_dado;
        fila_resp.push_back(r);

        inicio = 1'b1;  op_load = ld;  op_store = st;  endereco = ad;  dado_escrita = wd;
        mem_pronta = 1'($urandom_range(0, 1));
        mem_dado_lido = $urandom;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clock);
            inicio       = 1'($urandom_range(0, 1));
            op_load      = 1'($urandom_range(0, 1));
            op_store     = 1'($urandom_range(0, 1));
            endereco     = $urandom;
            dado_escrita = $urandom;
            if (acessa && c >= 2 && c < lat) begin
                mem_pronta    = (atraso >= 0) && (c == 2 + atraso);
                mem_dado_lido = mem_pronta ? rd : $urandom;
            end else begin
                mem_pronta    = 1'($urandom_range(0, 1));
                mem_dado_lido = $urandom;
            end
        end
        @(negedge clock);
        inicio = 1'b0;
        mem_pronta = 1'b0;
    endtask

    task automatic reset_no_meio();
        acesso_t a;
        a.we = 1'b0;  a.ende = 32'h40;  a.dado = 32'hCAFE0001;  a.ciclos = 0;
        fila_mem.push_back(a);
        inicio = 1'b1;  op_load = 1'b1;  op_store = 1'b0;  endereco = 32'h40;  dado_escrita = 32'hCAFE0001;
        @(negedge clock);
        inicio = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checa("rst_async_mem_en", 64'(mem_en), 64'(0));
        checa("rst_async_mem_we", 64'(mem_we), 64'(0));
        checa("rst_async_flag", 64'(flag), 64'(0));
        checa("rst_async_dado_lido", 64'(dado_lido), 64'(0));
        checa("rst_async_ocupado", 64'(ocupado), 64'(0));
        checa("rst_async_mem_end", 64'(mem_end), 64'(0));
        fila_resp.delete();
        fila_mem.delete();
        m_dado = '0;
        m_flag = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of run expected completion before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          ld, st;
        logic [LE-1:0] ad;
        int            tipo;

        @(negedge clock);
        @(negedge clock);
        checa("reset_mem_en", 64'(mem_en), 64'(0));
        checa("reset_mem_we", 64'(mem_we), 64'(0));
        checa("reset_mem_end", 64'(mem_end), 64'(0));
        checa("reset_mem_dado_esc", 64'(mem_dado_esc), 64'(0));
        checa("reset_dado_lido", 64'(dado_lido), 64'(0));
        checa("reset_flag", 64'(flag), 64'(0));
        checa("reset_ocupado", 64'(ocupado), 64'(0));
        checa("reset_concluido", 64'(concluido), 64'(0));
        checa("reset_erro", 64'(erro), 64'(0));
        reset = 1'b0;
        @(negedge clock);

        pedido(1'b1, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF);
        pedido(1'b0, 1'b1, 32'h20, 32'h12345678, 0, 32'h0);
        pedido(1'b1, 1'b0, 32'h13, 32'h0, 0, 32'h0);
        pedido(1'b1, 1'b0, 32'h30, 32'h0, -1, 32'h0);
        pedido(1'b1, 1'b0, 32'h34, 32'h0, TO - 1, 32'hA5A5F00F);
        pedido(1'b0, 1'b0, 32'h01, 32'h0, 0, 32'h0);
        pedido(1'b1, 1'b1, 32'h44, 32'h0, 0, 32'h0);
        pedido(1'b0, 1'b1, 32'h46, 32'h77, 0, 32'h0);
        pedido(1'b0, 1'b1, 32'h48, 32'h99, -1, 32'h0);
        pedido(1'b1, 1'b0, 32'h50, 32'h0, 1, 32'h0BADF00D);

        reset_no_meio();
        pedido(1'b1, 1'b0, 32'h60, 32'h0, 1, 32'h13572468);

        for (int i = 0; i < 150; i++) begin
            tipo = $urandom_range(0, 9);
            ad   = $urandom;
            ad[1:0] = 2'b00;
            ld = 1'($urandom_range(0, 1));
            st = !ld;
            if (tipo == 0) begin
                ld = 1'b0;  st = 1'b0;
            end else if (tipo == 1) begin
                ld = 1'b1;  st = 1'b1;
            end else if (tipo == 2) begin
                ad[1:0] = 2'($urandom_range(1, 3));
            end
            pedido(ld, st, ad, $urandom, $urandom_range(0, TO + 1), $urandom);
        end

        @(negedge clock);
        @(negedge clock);
        checa("fila_resp_vazia", 64'(fila_resp.size()), 64'(0));
        checa("fila_mem_vazia", 64'(fila_mem.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
